// File: rtl/seqmult_pkg.sv
// Shared types and helpers for the parametrised shift-add multiplier.
// The package stays width-agnostic, so magnitude handling works on MAX_WIDTH bits.
package seqmult_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        FIX
    } state_t;

    localparam int MAX_WIDTH = 32;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    // The caller sign-extends signed operands to MAX_WIDTH first, so the
    // negation of -2^(WIDTH-1) lands on +2^(WIDTH-1) in the low WIDTH bits.
    function automatic logic [MAX_WIDTH-1:0] abs_w(input logic [MAX_WIDTH-1:0] value,
                                                   input logic               signed_mode);
        if (signed_mode && value[MAX_WIDTH-1]) begin
            return ~value + MAX_WIDTH'(1);
        end
        return value;
    endfunction

endpackage

// File: rtl/seqmult_if.sv
// Operand/result bundle between a datapath controller and the sequential multiplier.
interface seqmult_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               load;
    logic               signed_mode;
    logic [2*WIDTH-1:0] op;
    logic               ready_out;
    logic               busy;
    logic               done;

    modport master (
        output a, b, load, signed_mode,
        input  op, ready_out, busy, done
    );

    modport slave (
        input  a, b, load, signed_mode,
        output op, ready_out, busy, done
    );
endinterface

// File: rtl/seqmult_param.sv
// Radix-2 shift-add multiplier: magnitudes are multiplied unsigned over WIDTH
// iterations, then the FIX state applies the sign and publishes the product.
module seqmult_param
    import seqmult_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic      clk,
    input  logic      rst_a,
    seqmult_if.slave  bus
);

    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = cnt_width(WIDTH);

    state_t             state_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [PW-1:0]      acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               sign_q;
    logic [PW-1:0]      op_q;
    logic               done_q;

    logic [MAX_WIDTH-1:0] a_ext;
    logic [MAX_WIDTH-1:0] b_ext;
    logic [MAX_WIDTH-1:0] a_abs;
    logic [MAX_WIDTH-1:0] b_abs;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;

    assign a_ext = bus.signed_mode ? MAX_WIDTH'(signed'(bus.a)) : MAX_WIDTH'(bus.a);
    assign b_ext = bus.signed_mode ? MAX_WIDTH'(signed'(bus.b)) : MAX_WIDTH'(bus.b);
    assign a_abs = abs_w(a_ext, bus.signed_mode);
    assign b_abs = abs_w(b_ext, bus.signed_mode);
    assign a_mag = a_abs[WIDTH-1:0];
    assign b_mag = b_abs[WIDTH-1:0];

    // Upper magnitude bits are always zero for legal widths.
    if (WIDTH < MAX_WIDTH) begin : g_trim
        logic unused_hi;
        assign unused_hi = ^{a_abs[MAX_WIDTH-1:WIDTH], b_abs[MAX_WIDTH-1:WIDTH]};
    end

    always_ff @(posedge clk) begin
        if (!rst_a) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            op_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.load) begin
                        mcand_q  <= a_mag;
                        mplier_q <= b_mag;
                        sign_q   <= bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        state_q  <= BUSY;
                    end
                end
                BUSY: begin
                    if (mplier_q[0]) begin
                        acc_q <= acc_q + (PW'(mcand_q) << cnt_q);
                    end
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    op_q    <= sign_q ? -acc_q : acc_q;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.op        = op_q;
    assign bus.done      = done_q;
    assign bus.ready_out = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: doc/seqmult_param.md
Name: seqmult_param

Overview:
- Parametrised radix-2 shift-add sequential multiplier; successor to the fixed 4-bit seqmult.
- Adds a WIDTH parameter, a per-operation signed/unsigned mode, a busy indication and a one-cycle done pulse.
- Sits as an arithmetic slave in datapath blocks; a controller presents operands with load and collects op when done pulses.

Parameters:
- WIDTH, 4, operand width in bits; legal range 2..32; product is 2*WIDTH bits.

Ports:
- clk  input  1  rising-edge clock.
- rst_a  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- load  input  1  start request, sampled on the rising edge of clk.
- signed_mode  input  1  1 = a and b are two's complement; 0 = unsigned; sampled with load.
- op  output  2*WIDTH  product; holds its last value until the next result is written.
- ready_out  output  1  1 = idle, next load will be accepted.
- busy  output  1  1 = operation in progress; always the inverse of ready_out.
- done  output  1  single-cycle pulse marking the cycle in which a new op first appears.

Behaviour:
- Reset (rst_a=0 at an edge):
  - State goes to IDLE; op=0, ready_out=1, busy=0, done=0.
  - Internal accumulator, operand registers and counter are cleared.
  - Reset mid-operation aborts it; no done pulse is produced for it.
- States: IDLE, BUSY, FIX.
- IDLE:
  - ready_out=1.
  - load=1 at an edge is accepted at that edge (edge E).
  - At E the block latches |a|, |b| and the sign flag s = signed_mode & (a[MSB]^b[MSB]).
  - When signed_mode=0, the magnitudes are the raw operands and s=0.
  - Magnitudes are WIDTH-bit unsigned, so -2^(WIDTH-1) maps to 2^(WIDTH-1).
  - Accumulator is cleared; counter set to 0; state goes to BUSY.
- BUSY, one iteration per edge:
  - If multiplier LSB=1, accumulator += multiplicand shifted left by the counter value.
  - The multiplier register shifts right by 1; the counter increments.
  - After WIDTH iterations (edge E+WIDTH), state goes to FIX.
  - The accumulator is 2*WIDTH bits wide; unsigned sums never overflow.
- FIX, edge E+WIDTH+1:
  - op <= s ? (two's-complement negation of accumulator) : accumulator.
  - done=1 for exactly the following cycle; state returns to IDLE, so ready_out=1 in that same cycle.
- Latency: op valid and done high in the cycle after edge E+WIDTH+1. For WIDTH=4 that is 6 edges after acceptance, inclusive of the accepting edge.
- load while BUSY or FIX is ignored; it is neither queued nor allowed to disturb operands.
- load=1 in the done cycle (IDLE) is accepted; back-to-back throughput is one result per WIDTH+2 cycles.
- a, b and signed_mode are don't-care except at the accepting edge.
- Signed range: the worst case, (-2^(WIDTH-1))^2 = 2^(2*WIDTH-2), fits a signed 2*WIDTH result. No saturation or overflow flag is required.
- rst_a=0 has priority over load at the same edge.

Decomposition:
- Package seqmult_pkg:
  - state enum {IDLE, BUSY, FIX};
  - localparam for counter width, $clog2(WIDTH+1);
  - function abs_w(value, signed_mode) returning the WIDTH-bit magnitude.
- Single module, no sub-module. The datapath (accumulator, shift registers, negate) is small enough to share the FSM process file.

Test Plan:
- WIDTH=4, unsigned, a=7, b=1, load pulsed 1 cycle after reset release -> op=8'h07, done high exactly 6 edges after the accepting edge, ready_out=1 from the same cycle.
- WIDTH=4, unsigned, a=15, b=15 -> op=8'hE1 (225); then signed, a=4'b1000, b=4'b1000 (-8*-8) -> op=8'h40 (64).
- WIDTH=4, signed, a=-3 (4'hD), b=5 -> op=8'hF1 (-15); signed a=7, b=-1 -> op=8'hF9 (-7).
- Start 3*5 unsigned; assert load with a=9, b=9 during BUSY -> ignored, op=8'h0F, single done. Then load held high through done -> the second op (81=8'h51) follows exactly WIDTH+2 cycles later.
- Start 6*6; assert rst_a=0 at edge E+2 -> op=0, ready_out=1, busy=0, no done. After release, a new 2*3 completes with op=6.
- WIDTH=8: unsigned 255*255 -> op=16'hFE01; signed -128*127 -> op=16'hC080; done exactly 10 edges after acceptance.
